// File: rtl/ccb_addr_walker_if.sv
// Bundles config, request and response signals of the CCB address walker.
// Latency: none (wiring only).
// Backpressure: req_valid/req_ready and rsp_valid/rsp_ready handshakes.
interface ccb_addr_walker_if #(
    parameter int ADDR_W = 44,
    parameter int IDX_W  = 32,
    parameter int CH_W   = 2,
    parameter int SIZE_W = 2
);
    logic              cfg_we;
    logic [CH_W-1:0]   cfg_ch;
    logic [ADDR_W-1:0] cfg_base;
    logic [SIZE_W-1:0] cfg_size;
    logic [IDX_W-1:0]  cfg_limit;
    logic              req_valid;
    logic              req_ready;
    logic [CH_W-1:0]   req_ch;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [ADDR_W-1:0] rsp_addr;
    logic [CH_W-1:0]   rsp_ch;
    logic              rsp_wrap;
    logic              rsp_ovf;
    logic              busy;

    modport master (
        output cfg_we, cfg_ch, cfg_base, cfg_size, cfg_limit,
        output req_valid, req_ch, rsp_ready,
        input  req_ready, rsp_valid, rsp_addr, rsp_ch, rsp_wrap, rsp_ovf, busy
    );

    modport slave (
        input  cfg_we, cfg_ch, cfg_base, cfg_size, cfg_limit,
        input  req_valid, req_ch, rsp_ready,
        output req_ready, rsp_valid, rsp_addr, rsp_ch, rsp_wrap, rsp_ovf, busy
    );
endinterface

// File: rtl/ccb_addr_walker.sv
// Multi-channel CCB address generator: addr = base + (index << size), index walks 0..limit.
// Latency: 2 register stages, response valid after the edge following accept; 1 req/cycle.
// Backpressure: S2 stalls on !rsp_ready, S1 stalls behind it; req_ready has no path from req_valid.
module ccb_addr_walker #(
    parameter int ADDR_W = 44,
    parameter int IDX_W  = 32,
    parameter int NUM_CH = 4,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    parameter int SIZE_W = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    ccb_addr_walker_if.slave   bus
);
    // The widest shifted index must fit in the address so only the final add can carry out.
    if (ADDR_W < IDX_W + (1 << SIZE_W) - 1) begin : g_width_check
        $error("ccb_addr_walker: ADDR_W too small for IDX_W shifted by the largest size code");
    end
    if (NUM_CH < 1) begin : g_ch_check
        $error("ccb_addr_walker: NUM_CH must be at least 1");
    end

    localparam int SUM_W = ADDR_W + 1;

    // Per-channel configuration and walk position
    logic [ADDR_W-1:0] base_q  [NUM_CH];
    logic [SIZE_W-1:0] size_q  [NUM_CH];
    logic [IDX_W-1:0]  limit_q [NUM_CH];
    logic [IDX_W-1:0]  idx_q   [NUM_CH];

    // Stage 1: captured request operands
    logic              s1_valid_q;
    logic [CH_W-1:0]   s1_ch_q;
    logic [IDX_W-1:0]  s1_idx_q;
    logic [ADDR_W-1:0] s1_base_q;
    logic [SIZE_W-1:0] s1_size_q;
    logic              s1_wrap_q;

    // Stage 2: registered response
    logic              rsp_valid_q;
    logic [ADDR_W-1:0] rsp_addr_q;
    logic [CH_W-1:0]   rsp_ch_q;
    logic              rsp_wrap_q;
    logic              rsp_ovf_q;

    logic              s2_load;
    logic              s1_adv;
    logic              accept;
    logic              ch_ok;
    logic [IDX_W-1:0]  sel_idx;
    logic [ADDR_W-1:0] sel_base;
    logic [SIZE_W-1:0] sel_size;
    logic [IDX_W-1:0]  sel_limit;
    logic              sel_wrap;
    logic [IDX_W-1:0]  idx_d;
    logic [SUM_W-1:0]  sum_d;

    assign s2_load       = !rsp_valid_q || bus.rsp_ready;
    assign s1_adv        = !s1_valid_q || s2_load;
    assign accept        = bus.req_valid && s1_adv;
    assign ch_ok         = (int'(bus.req_ch) < NUM_CH);

    assign bus.req_ready = s1_adv;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_addr  = rsp_addr_q;
    assign bus.rsp_ch    = rsp_ch_q;
    assign bus.rsp_wrap  = rsp_wrap_q;
    assign bus.rsp_ovf   = rsp_ovf_q;
    assign bus.busy      = s1_valid_q || rsp_valid_q;

    // Look up the requesting channel; an unmapped channel reads as all-zero with no wrap
    always_comb begin
        sel_idx   = '0;
        sel_base  = '0;
        sel_size  = '0;
        sel_limit = '0;
        if (ch_ok) begin
            sel_idx   = idx_q[bus.req_ch];
            sel_base  = base_q[bus.req_ch];
            sel_size  = size_q[bus.req_ch];
            sel_limit = limit_q[bus.req_ch];
        end
        sel_wrap = ch_ok && (sel_idx == sel_limit);
        idx_d    = sel_wrap ? '0 : sel_idx + IDX_W'(1);
    end

    // Shift is lossless by the width check, so the only possible carry is from the base add
    assign sum_d = (SUM_W'(s1_idx_q) << s1_size_q) + SUM_W'(s1_base_q);

    // Channel state: a config write beats a same-cycle index advance on that channel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                base_q[c]  <= '0;
                size_q[c]  <= '0;
                limit_q[c] <= '0;
                idx_q[c]   <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (bus.cfg_we && (int'(bus.cfg_ch) == c)) begin
                    base_q[c]  <= bus.cfg_base;
                    size_q[c]  <= bus.cfg_size;
                    limit_q[c] <= bus.cfg_limit;
                    idx_q[c]   <= '0;
                end else if (accept && ch_ok && (int'(bus.req_ch) == c)) begin
                    idx_q[c]   <= idx_d;
                end
            end
        end
    end

    // S1 captures the pre-write channel operands whenever it can advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_ch_q    <= '0;
            s1_idx_q   <= '0;
            s1_base_q  <= '0;
            s1_size_q  <= '0;
            s1_wrap_q  <= 1'b0;
        end else if (s1_adv) begin
            s1_valid_q <= bus.req_valid;
            if (bus.req_valid) begin
                s1_ch_q   <= bus.req_ch;
                s1_idx_q  <= sel_idx;
                s1_base_q <= sel_base;
                s1_size_q <= sel_size;
                s1_wrap_q <= sel_wrap;
            end
        end
    end

    // S2 registers the sum; outputs only change when the consumer can take them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_addr_q  <= '0;
            rsp_ch_q    <= '0;
            rsp_wrap_q  <= 1'b0;
            rsp_ovf_q   <= 1'b0;
        end else if (s2_load) begin
            rsp_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                rsp_addr_q <= sum_d[ADDR_W-1:0];
                rsp_ovf_q  <= sum_d[ADDR_W];
                rsp_ch_q   <= s1_ch_q;
                rsp_wrap_q <= s1_wrap_q;
            end
        end
    end
endmodule

// File: tb/tb_ccb_addr_walker.sv
// Self-checking bench for ccb_addr_walker: directed scenarios plus randomized traffic.
// Expected responses come from a per-channel arithmetic model and an in-order queue.
// Inputs change on the falling edge; outputs are sampled 1ns after it.
module tb_ccb_addr_walker;
    localparam int ADDR_W = 44;
    localparam int IDX_W  = 32;
    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;
    localparam int SIZE_W = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ccb_addr_walker_if #(.ADDR_W(ADDR_W), .IDX_W(IDX_W), .CH_W(CH_W), .SIZE_W(SIZE_W)) bus ();

    ccb_addr_walker #(
        .ADDR_W(ADDR_W), .IDX_W(IDX_W), .NUM_CH(NUM_CH), .CH_W(CH_W), .SIZE_W(SIZE_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [CH_W-1:0]   ch;
        logic              wrap;
        logic              ovf;
        int                cyc;
    } rsp_t;

    // Reference model state
    longint unsigned m_base  [NUM_CH];
    int unsigned     m_size  [NUM_CH];
    int unsigned     m_limit [NUM_CH];
    int unsigned     m_idx   [NUM_CH];
    rsp_t            exp_q [$];
    rsp_t            done_q[$];
    rsp_t            got_q [$];

    int   n_checks = 0;
    int   n_err    = 0;
    int   cyc      = 0;
    int   acc_cnt  = 0;
    int   spurious = 0;
    logic last_rdy;
    logic last_exp_rdy;

    always @(posedge clk) cyc = cyc + 1;

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_base[c]  = 0;
            m_size[c]  = 0;
            m_limit[c] = 0;
            m_idx[c]   = 0;
        end
        exp_q.delete();
        done_q.delete();
        got_q.delete();
    endtask

    task automatic idle_inputs();
        bus.cfg_we    = 1'b0;
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
    endtask

    // One clock: observe handshakes, advance the model, move to the next falling edge
    task automatic step();
        rsp_t            o;
        rsp_t            e;
        longint unsigned full;
        longint unsigned idx64;
        int              c;
        logic            acc;
        #1;
        last_rdy     = bus.req_ready;
        last_exp_rdy = (exp_q.size() < 2) || bus.rsp_ready;
        acc          = bus.req_valid && bus.req_ready;
        if (bus.rsp_valid && bus.rsp_ready) begin
            o.addr = bus.rsp_addr;
            o.ch   = bus.rsp_ch;
            o.wrap = bus.rsp_wrap;
            o.ovf  = bus.rsp_ovf;
            o.cyc  = cyc;
            got_q.push_back(o);
            if (exp_q.size() > 0) done_q.push_back(exp_q.pop_front());
            else spurious++;
        end
        if (acc) begin
            acc_cnt++;
            c      = int'(bus.req_ch);
            idx64  = longint'(m_idx[c]);
            full   = (idx64 << m_size[c]) + m_base[c];
            e.addr = full[ADDR_W-1:0];
            e.ovf  = full[ADDR_W];
            e.wrap = (m_idx[c] == m_limit[c]);
            e.ch   = bus.req_ch;
            e.cyc  = 0;
            exp_q.push_back(e);
            m_idx[c] = (m_idx[c] == m_limit[c]) ? 0 : m_idx[c] + 1;
        end
        if (bus.cfg_we) begin
            c          = int'(bus.cfg_ch);
            m_base[c]  = longint'(bus.cfg_base);
            m_size[c]  = int'(bus.cfg_size);
            m_limit[c] = bus.cfg_limit;
            m_idx[c]   = 0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        idle_inputs();
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) step();
    endtask

    task automatic cfg_write(input int ch, input logic [ADDR_W-1:0] base,
                             input int size, input int unsigned limit);
        bus.cfg_we    = 1'b1;
        bus.cfg_ch    = CH_W'(ch);
        bus.cfg_base  = base;
        bus.cfg_size  = SIZE_W'(size);
        bus.cfg_limit = limit;
        bus.req_valid = 1'b0;
        step();
        bus.cfg_we    = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.cfg_ch = '0; bus.cfg_base = '0; bus.cfg_size = '0; bus.cfg_limit = '0;
        bus.req_ch = '0;
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        #1;
        n_checks++;
        if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin
            n_err++; $display("FAIL reset_valid_busy: got rsp_valid=%b busy=%b, required 0 0", bus.rsp_valid, bus.busy);
        end
        n_checks++;
        if (bus.rsp_addr !== '0 || bus.rsp_ch !== '0 || bus.rsp_wrap !== 1'b0 || bus.rsp_ovf !== 1'b0) begin
            n_err++; $display("FAIL reset_rsp_fields: got addr=%h ch=%0d wrap=%b ovf=%b, required all 0",
                              bus.rsp_addr, bus.rsp_ch, bus.rsp_wrap, bus.rsp_ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        n_checks++;
        if (bus.req_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_req_ready: got %b required 1", bus.req_ready);
        end
    endtask

    task automatic test_default_ch0();
        got_q.delete(); done_q.delete();
        bus.req_valid = 1'b1; bus.req_ch = 2'd0; bus.rsp_ready = 1'b1;
        step();
        bus.req_valid = 1'b0; bus.rsp_ready = 1'b0;
        #1;
        n_checks++;
        if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b1) begin
            n_err++; $display("FAIL ch0_after_accept: got rsp_valid=%b busy=%b, required 0 1", bus.rsp_valid, bus.busy);
        end
        step();
        n_checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_addr !== '0 || bus.rsp_wrap !== 1'b1 || bus.rsp_ovf !== 1'b0) begin
            n_err++; $display("FAIL ch0_response: got valid=%b addr=%h wrap=%b ovf=%b, required 1 0 1 0",
                              bus.rsp_valid, bus.rsp_addr, bus.rsp_wrap, bus.rsp_ovf);
        end
        bus.rsp_ready = 1'b1;
        step();
        n_checks++;
        if (bus.busy !== 1'b0 || got_q.size() != 1) begin
            n_err++; $display("FAIL ch0_idle: got busy=%b responses=%0d, required 0 1", bus.busy, got_q.size());
        end
    endtask

    task automatic test_ch1_seq();
        logic [ADDR_W-1:0] ea [4];
        logic              ew [4];
        ea = '{44'h100, 44'h104, 44'h108, 44'h100};
        ew = '{1'b0, 1'b0, 1'b1, 1'b0};
        cfg_write(1, 44'h100, 2, 2);
        got_q.delete(); done_q.delete();
        for (int i = 0; i < 4; i++) begin
            bus.req_valid = 1'b1; bus.req_ch = 2'd1; bus.rsp_ready = 1'b1;
            step();
            n_checks++;
            if (last_rdy !== 1'b1) begin
                n_err++; $display("FAIL ch1_seq_ready[%0d]: got %b required 1", i, last_rdy);
            end
        end
        drain();
        n_checks++;
        if (got_q.size() != 4) begin
            n_err++; $display("FAIL ch1_seq_count: got %0d required 4", got_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (got_q[i].addr !== ea[i] || got_q[i].wrap !== ew[i] || got_q[i].ch !== 2'd1
                    || got_q[i].cyc != got_q[0].cyc + i) begin
                    n_err++; $display("FAIL ch1_seq[%0d]: got addr=%h wrap=%b ch=%0d cyc+%0d, required addr=%h wrap=%b ch=1 cyc+%0d",
                                      i, got_q[i].addr, got_q[i].wrap, got_q[i].ch, got_q[i].cyc - got_q[0].cyc, ea[i], ew[i], i);
                end
            end
        end
    endtask

    task automatic test_overflow();
        cfg_write(2, 44'hFFFFFFFFFFC, 3, 7);
        got_q.delete(); done_q.delete();
        bus.req_valid = 1'b1; bus.req_ch = 2'd2;
        step();
        step();
        drain();
        n_checks++;
        if (got_q.size() != 2) begin
            n_err++; $display("FAIL ovf_count: got %0d required 2", got_q.size());
        end else begin
            n_checks++;
            if (got_q[0].addr !== 44'hFFFFFFFFFFC || got_q[0].ovf !== 1'b0) begin
                n_err++; $display("FAIL ovf_first: got addr=%h ovf=%b, required FFFFFFFFFFC 0", got_q[0].addr, got_q[0].ovf);
            end
            n_checks++;
            if (got_q[1].addr !== 44'h00000000004 || got_q[1].ovf !== 1'b1) begin
                n_err++; $display("FAIL ovf_second: got addr=%h ovf=%b, required 00000000004 1", got_q[1].addr, got_q[1].ovf);
            end
        end
    endtask

    task automatic test_stall();
        int                a0;
        logic [ADDR_W-1:0] hold;
        got_q.delete(); done_q.delete();
        a0   = acc_cnt;
        hold = '0;
        bus.req_valid = 1'b1; bus.req_ch = 2'd1; bus.rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if (last_rdy !== last_exp_rdy) begin
                n_err++; $display("FAIL stall_ready[%0d]: got %b required %b", i, last_rdy, last_exp_rdy);
            end
            if (i == 1) hold = bus.rsp_addr;
        end
        #1;
        n_checks++;
        if (acc_cnt - a0 != 2 || bus.req_ready !== 1'b0) begin
            n_err++; $display("FAIL stall_accepts: got accepted=%0d req_ready=%b, required 2 0", acc_cnt - a0, bus.req_ready);
        end
        n_checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_addr !== hold || bus.rsp_addr !== 44'h104) begin
            n_err++; $display("FAIL stall_stable: got valid=%b addr=%h, required 1 104", bus.rsp_valid, bus.rsp_addr);
        end
        drain();
        n_checks++;
        if (got_q.size() != 2 || got_q[0].addr !== 44'h104 || got_q[1].addr !== 44'h108 || got_q[1].wrap !== 1'b1) begin
            n_err++; $display("FAIL stall_drain: got %0d responses first=%h second=%h, required 2 104 108(wrap)",
                              got_q.size(), got_q.size() > 0 ? got_q[0].addr : '0, got_q.size() > 1 ? got_q[1].addr : '0);
        end
    endtask

    task automatic test_cfg_collision();
        logic [ADDR_W-1:0] ea [6];
        logic [CH_W-1:0]   ec [6];
        ea = '{44'h100, 44'h2000, 44'h104, 44'h2002, 44'h5000, 44'h2004};
        ec = '{2'd1, 2'd3, 2'd1, 2'd3, 2'd1, 2'd3};
        cfg_write(3, 44'h2000, 1, 3);
        got_q.delete(); done_q.delete();
        for (int i = 0; i < 6; i++) begin
            bus.req_valid = 1'b1; bus.req_ch = ec[i]; bus.rsp_ready = 1'b1;
            bus.cfg_we = (i == 2);
            bus.cfg_ch = 2'd1; bus.cfg_base = 44'h5000; bus.cfg_size = 2'd0; bus.cfg_limit = 5;
            step();
        end
        drain();
        n_checks++;
        if (got_q.size() != 6) begin
            n_err++; $display("FAIL collide_count: got %0d required 6", got_q.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_checks++;
                if (got_q[i].addr !== ea[i] || got_q[i].ch !== ec[i]) begin
                    n_err++; $display("FAIL collide[%0d]: got addr=%h ch=%0d, required addr=%h ch=%0d",
                                      i, got_q[i].addr, got_q[i].ch, ea[i], ec[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [ADDR_W-1:0] b;
        got_q.delete(); done_q.delete();
        spurious = 0;
        for (int i = 0; i < 400; i++) begin
            bus.req_valid = ($urandom_range(0, 3) != 0);
            bus.req_ch    = CH_W'($urandom_range(0, NUM_CH - 1));
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            bus.cfg_we    = ($urandom_range(0, 15) == 0);
            bus.cfg_ch    = CH_W'($urandom_range(0, NUM_CH - 1));
            b = {12'($urandom), 32'($urandom)};
            if ($urandom_range(0, 1) == 1) b = 44'hFFFFFFFFF00 | ADDR_W'(8'($urandom));
            bus.cfg_base  = b;
            bus.cfg_size  = SIZE_W'($urandom_range(0, 3));
            bus.cfg_limit = $urandom_range(0, 6);
            step();
            n_checks++;
            if (last_rdy !== last_exp_rdy) begin
                n_err++; $display("FAIL rand_ready[%0d]: got %b required %b", i, last_rdy, last_exp_rdy);
            end
        end
        drain();
        n_checks++;
        if (exp_q.size() != 0 || spurious != 0 || got_q.size() != done_q.size()) begin
            n_err++; $display("FAIL rand_drain: got outstanding=%0d spurious=%0d resp=%0d, required 0 0 %0d",
                              exp_q.size(), spurious, got_q.size(), done_q.size());
        end else begin
            for (int i = 0; i < got_q.size(); i++) begin
                n_checks++;
                if (got_q[i].addr !== done_q[i].addr || got_q[i].ch !== done_q[i].ch
                    || got_q[i].wrap !== done_q[i].wrap || got_q[i].ovf !== done_q[i].ovf) begin
                    n_err++; $display("FAIL rand_rsp[%0d]: got addr=%h ch=%0d wrap=%b ovf=%b, required addr=%h ch=%0d wrap=%b ovf=%b",
                                      i, got_q[i].addr, got_q[i].ch, got_q[i].wrap, got_q[i].ovf,
                                      done_q[i].addr, done_q[i].ch, done_q[i].wrap, done_q[i].ovf);
                end
            end
        end
    endtask

    task automatic test_reset_midflight();
        cfg_write(1, 44'h700, 1, 4);
        got_q.delete(); done_q.delete();
        bus.req_valid = 1'b1; bus.req_ch = 2'd1; bus.rsp_ready = 1'b0;
        step();
        step();
        bus.req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin
            n_err++; $display("FAIL midreset_drop: got rsp_valid=%b busy=%b, required 0 0", bus.rsp_valid, bus.busy);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        bus.req_valid = 1'b1; bus.req_ch = 2'd1; bus.rsp_ready = 1'b1;
        step();
        drain();
        n_checks++;
        if (got_q.size() != 1 || got_q[0].addr !== '0 || got_q[0].wrap !== 1'b1 || got_q[0].ch !== 2'd1) begin
            n_err++; $display("FAIL midreset_after: got %0d responses addr=%h wrap=%b, required 1 0 1",
                              got_q.size(), got_q.size() > 0 ? got_q[0].addr : '1, got_q.size() > 0 ? got_q[0].wrap : 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_default_ch0();
        test_ch1_seq();
        test_overflow();
        test_stall();
        test_cfg_collision();
        test_random();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $display("Result: errors=%0d of %0d checks", n_err + 1, n_checks + 1);
        $fatal(1, "timeout");
    end
endmodule
